vga_frame_monitor: RTL and testbench

//  Receive-side VGA monitor: samples VGA_CLK/HS/VS/BLANK/RGB from the video generator and checks them.

---
 rtl/vga_frame_monitor.sv | 200 ++++++++++++++++++++
 tb/tb_vga_frame_monitor.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_monitor.sv
// Receive-side VGA checker: measures line/frame geometry against nominal timing, counts frames,
// flags sticky errors and runs a lock FSM. Define VGA_MON_CSUM_EN to enable the frame content signature.
module vga_frame_monitor #(
  parameter int H_TOTAL  = 800,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_ACTIVE = 480,
  parameter int TIMEOUT  = 64
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        vga_clk,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  input  logic        clear_err,
  output logic [1:0]  state,
  output logic        locked,
  output logic [11:0] h_total_meas,
  output logic [11:0] v_total_meas,
  output logic [15:0] frame_count,
  output logic        frame_done,
  output logic [3:0]  err,
  output logic [23:0] frame_csum
);

  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [11:0] H_TOT = 12'(H_TOTAL);
  localparam logic [11:0] H_ACT = 12'(H_ACTIVE);
  localparam logic [11:0] V_TOT = 12'(V_TOTAL);
  localparam logic [11:0] V_ACT = 12'(V_ACTIVE);
  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT);
  localparam logic [SW-1:0] STALL_HIT = SW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t        st;
  logic          vga_clk_q;
  logic          hs_q;
  logic          vs_q;
  logic          h_seen;
  logic [11:0]   pix_cnt;
  logic [11:0]   act_cnt;
  logic [11:0]   line_cnt;
  logic [11:0]   vis_cnt;
  logic [SW-1:0] stall_cnt;

  logic          pix_stb;
  logic          hs_fall;
  logic          vs_fall;
  logic          checking;
  logic          line_chk;
  logic          line_vis;
  logic          timeout_hit;
  logic [11:0]   lines_now;
  logic [11:0]   vis_now;
  logic [3:0]    new_err;

  assign pix_stb  = vga_clk & ~vga_clk_q;
  assign hs_fall  = pix_stb & hs_q & ~vga_hs;
  assign vs_fall  = pix_stb & vs_q & ~vga_vs;
  assign checking = (st == ALIGN) || (st == LOCKED);
  // h_seen keeps the first partial line after reset out of the line checks
  assign line_chk = hs_fall & checking & h_seen;
  assign line_vis = (act_cnt != 12'd0);

  // A line closed on the same strobe as the frame still belongs to the closing frame
  assign lines_now = line_cnt + {11'd0, hs_fall};
  assign vis_now   = vis_cnt + {11'd0, hs_fall & line_vis};

  assign timeout_hit = ~pix_stb & (st != IDLE) & (stall_cnt == STALL_HIT);

  assign new_err[0] = line_chk & (pix_cnt != H_TOT);
  assign new_err[1] = line_chk & line_vis & (act_cnt != H_ACT);
  assign new_err[2] = vs_fall & checking & ((lines_now != V_TOT) || (vis_now != V_ACT));
  assign new_err[3] = timeout_hit;

  assign state = st;

  // Pixel-strobe front end and line/frame geometry counters
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      vga_clk_q    <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      h_seen       <= 1'b0;
      pix_cnt      <= 12'd0;
      act_cnt      <= 12'd0;
      line_cnt     <= 12'd0;
      vis_cnt      <= 12'd0;
      stall_cnt    <= {SW{1'b0}};
      h_total_meas <= 12'd0;
      v_total_meas <= 12'd0;
    end else begin
      vga_clk_q <= vga_clk;
      stall_cnt <= pix_stb ? {SW{1'b0}} :
                   (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + SW'(1);
      if (pix_stb) begin
        hs_q <= vga_hs;
        vs_q <= vga_vs;
        if (hs_fall) begin
          h_total_meas <= pix_cnt;
          pix_cnt      <= 12'd1;
          act_cnt      <= {11'd0, vga_blank};
          h_seen       <= 1'b1;
          line_cnt     <= line_cnt + 12'd1;
          vis_cnt      <= vis_cnt + {11'd0, line_vis};
        end else begin
          pix_cnt <= (pix_cnt == 12'hFFF) ? pix_cnt : pix_cnt + 12'd1;
          act_cnt <= (vga_blank && act_cnt != 12'hFFF) ? act_cnt + 12'd1 : act_cnt;
        end
        if (vs_fall) begin
          v_total_meas <= lines_now;
          line_cnt     <= 12'd0;
          vis_cnt      <= 12'd0;
        end
      end
    end
  end

  // Lock FSM, sticky error flags and frame counting; a new error beats clear_err
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      st          <= IDLE;
      locked      <= 1'b0;
      err         <= 4'd0;
      frame_done  <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      err        <= (clear_err ? 4'd0 : err) | new_err;
      frame_done <= vs_fall & (st != IDLE);
      if (vs_fall && st != IDLE) begin
        frame_count <= frame_count + 16'd1;
      end
      case (st)
        IDLE: begin
          locked <= 1'b0;
          if (vs_fall) begin
            st <= ALIGN;
          end
        end
        ALIGN: begin
          if (new_err != 4'd0) begin
            st     <= FAULT;
            locked <= 1'b0;
          end else if (vs_fall) begin
            st     <= LOCKED;
            locked <= 1'b1;
          end
        end
        LOCKED: begin
          if (new_err != 4'd0) begin
            st     <= FAULT;
            locked <= 1'b0;
          end
        end
        FAULT: begin
          locked <= 1'b0;
          if (clear_err && new_err == 4'd0) begin
            st <= IDLE;
          end
        end
        default: begin
          st     <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_MON_CSUM_EN
  logic [23:0] csum;

  // Rotate-and-XOR signature over visible pixels, latched at each frame boundary
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      csum       <= 24'd0;
      frame_csum <= 24'd0;
    end else if (vs_fall) begin
      frame_csum <= csum;
      csum       <= 24'd0;
    end else if (pix_stb && vga_blank) begin
      csum <= {csum[22:0], csum[23]} ^ {vga_r, vga_g, vga_b};
    end
  end
`else
  logic unused_rgb;
  assign unused_rgb = ^{vga_r, vga_g, vga_b};
  assign frame_csum = 24'd0;
`endif

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Scoreboard bench for vga_frame_monitor on a reduced 20x10 raster (12x6 visible).
// Frame and fault expectations are queued by the stimulus and popped by an independent monitor.
module tb_vga_frame_monitor;

  localparam int HT = 20;
  localparam int HA = 12;
  localparam int VT = 10;
  localparam int VA = 6;
  localparam int TO = 16;
  localparam int HS0 = 4;

  logic        clock_50 = 1'b0;
  logic        reset = 1'b1;
  logic        vga_clk = 1'b0;
  logic        vga_hs = 1'b1;
  logic        vga_vs = 1'b1;
  logic        vga_blank = 1'b0;
  logic [7:0]  vga_r = 8'd0;
  logic [7:0]  vga_g = 8'd0;
  logic [7:0]  vga_b = 8'd0;
  logic        clear_err = 1'b0;
  logic [1:0]  state;
  logic        locked;
  logic [11:0] h_total_meas;
  logic [11:0] v_total_meas;
  logic [15:0] frame_count;
  logic        frame_done;
  logic [3:0]  err;
  logic [23:0] frame_csum;

  vga_frame_monitor #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA), .TIMEOUT(TO)
  ) dut (
    .clock_50(clock_50), .reset(reset), .vga_clk(vga_clk), .vga_hs(vga_hs),
    .vga_vs(vga_vs), .vga_blank(vga_blank), .vga_r(vga_r), .vga_g(vga_g),
    .vga_b(vga_b), .clear_err(clear_err), .state(state), .locked(locked),
    .h_total_meas(h_total_meas), .v_total_meas(v_total_meas),
    .frame_count(frame_count), .frame_done(frame_done), .err(err),
    .frame_csum(frame_csum)
  );

  always #5 clock_50 = ~clock_50;

  typedef struct packed {
    logic [1:0]  st;
    logic [3:0]  err;
    logic [15:0] cnt;
    logic [23:0] csum;
  } fexp_t;

  typedef struct packed {
    logic [3:0]  err;
    logic [11:0] h;
  } flt_t;

  fexp_t fq[$];
  flt_t  flq[$];
  int tests = 0;
  int failed = 0;
  logic [23:0] prev_csum = 24'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int f, input int l, input int x);
    logic [7:0] a, b, c;
    a = 8'(f * 16 + l);
    b = 8'(x * 7 + 3);
    c = 8'((l * 31) ^ x);
    if (f == 2) return 24'h000001;
    return {a, b, c};
  endfunction

  task automatic strobe(input logic hs, input logic vs, input logic bl, input logic [23:0] rgb);
    @(negedge clock_50);
    vga_hs = hs;
    vga_vs = vs;
    vga_blank = bl;
    {vga_r, vga_g, vga_b} = rgb;
    vga_clk = 1'b1;
    @(negedge clock_50);
    vga_clk = 1'b0;
  endtask

  // One frame starting with the VS/HS fall strobe; optional faults and early abort.
  task automatic send_frame(input int f, input int long_l, input int short_l, input int dark_l,
                            input int abort_l, input bit push, input logic [1:0] es,
                            input logic [3:0] ee, input logic [15:0] ec);
    fexp_t e;
    logic [23:0] acc;
    logic [23:0] rgb;
    logic bl;
    int len, act;
    if (push) begin
      e.st = es;
      e.err = ee;
      e.cnt = ec;
`ifdef VGA_MON_CSUM_EN
      e.csum = prev_csum;
`else
      e.csum = 24'd0;
`endif
      fq.push_back(e);
    end
    acc = 24'd0;
    for (int l = 0; l < VT; l++) begin
      len = (l == long_l) ? HT + 1 : HT;
      act = (l == short_l) ? HA - 1 : HA;
      for (int x = 0; x < len; x++) begin
        bl = (l >= 3) && (l < 3 + VA) && (l != dark_l) && (x >= HS0) && (x < HS0 + act);
        rgb = pix(f, l, x);
        if (bl) acc = {acc[22:0], acc[23]} ^ rgb;
        strobe(x >= 2, l >= 2, bl, rgb);
        if (l == abort_l && x == 10) return;
      end
    end
    prev_csum = acc;
  endtask

  task automatic push_fault(input logic [3:0] e, input logic [11:0] h);
    flt_t t;
    t.err = e;
    t.h = h;
    flq.push_back(t);
  endtask

  task automatic do_clear();
    @(negedge clock_50);
    clear_err = 1'b1;
    @(negedge clock_50);
    clear_err = 1'b0;
    chk("clear_state", {30'd0, state}, 32'd0);
    chk("clear_err", {28'd0, err}, 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, {30'd0, state}, 32'd0);
    chk({tag, "_locked"}, {31'd0, locked}, 32'd0);
    chk({tag, "_err"}, {28'd0, err}, 32'd0);
    chk({tag, "_fcnt"}, {16'd0, frame_count}, 32'd0);
    chk({tag, "_fdone"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_htot"}, {20'd0, h_total_meas}, 32'd0);
    chk({tag, "_vtot"}, {20'd0, v_total_meas}, 32'd0);
    chk({tag, "_csum"}, {8'd0, frame_csum}, 32'd0);
  endtask

  // Monitor: pops expectations on frame_done pulses and on entry into FAULT
  initial begin
    logic [1:0] prev_state;
    fexp_t e;
    flt_t t;
    prev_state = 2'd0;
    forever begin
      @(negedge clock_50);
      if (frame_done) begin
        if (fq.size() == 0) begin
          chk("unexpected_frame_done", 32'd1, 32'd0);
        end else begin
          e = fq.pop_front();
          chk("fd_state", {30'd0, state}, {30'd0, e.st});
          chk("fd_locked", {31'd0, locked}, {31'd0, e.st == 2'd2});
          chk("fd_err", {28'd0, err}, {28'd0, e.err});
          chk("fd_count", {16'd0, frame_count}, {16'd0, e.cnt});
          chk("fd_vtotal", {20'd0, v_total_meas}, VT);
          chk("fd_htotal", {20'd0, h_total_meas}, HT);
          chk("fd_csum", {8'd0, frame_csum}, {8'd0, e.csum});
        end
      end
      if (state == 2'd3 && prev_state != 2'd3) begin
        if (flq.size() == 0) begin
          chk("unexpected_fault", {28'd0, err}, 32'd0);
        end else begin
          t = flq.pop_front();
          chk("fault_err", {28'd0, err}, {28'd0, t.err});
          chk("fault_htotal", {20'd0, h_total_meas}, {20'd0, t.h});
          chk("fault_locked", {31'd0, locked}, 32'd0);
        end
      end
      prev_state = state;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clock_50);
    chk_zero("reset");
    reset = 1'b0;

    // Nominal lock-up: F1 enters ALIGN, F2 locks, F3 counts
    send_frame(0, -1, -1, -1, -1, 1'b0, 2'd0, 4'd0, 16'd0);
    send_frame(1, -1, -1, -1, -1, 1'b0, 2'd0, 4'd0, 16'd0);
    chk("align_state", {30'd0, state}, 32'd1);
    chk("align_err", {28'd0, err}, 32'd0);
    chk("align_count", {16'd0, frame_count}, 32'd0);
    send_frame(2, -1, -1, -1, -1, 1'b1, 2'd2, 4'd0, 16'd1);

    // Over-long line while locked
    push_fault(4'b0001, 12'(HT + 1));
    send_frame(3, 5, -1, -1, -1, 1'b1, 2'd2, 4'd0, 16'd2);
    do_clear();

    // Short visible line after re-lock
    send_frame(4, -1, -1, -1, -1, 1'b0, 2'd0, 4'd0, 16'd0);
    send_frame(5, -1, -1, -1, -1, 1'b1, 2'd2, 4'd0, 16'd3);
    push_fault(4'b0010, 12'(HT));
    send_frame(6, -1, 4, -1, -1, 1'b1, 2'd2, 4'd0, 16'd4);
    do_clear();

    // Pixel clock loss while locked
    send_frame(7, -1, -1, -1, -1, 1'b0, 2'd0, 4'd0, 16'd0);
    send_frame(8, -1, -1, -1, -1, 1'b1, 2'd2, 4'd0, 16'd5);
    send_frame(9, -1, -1, -1, -1, 1'b1, 2'd2, 4'd0, 16'd6);
    push_fault(4'b1000, 12'(HT));
    repeat (TO + 4) @(negedge clock_50);
    do_clear();

    // Reset mid-line, then re-lock from scratch
    send_frame(10, -1, -1, -1, 4, 1'b0, 2'd0, 4'd0, 16'd0);
    reset = 1'b1;
    #1;
    chk_zero("midreset");
    repeat (3) @(negedge clock_50);
    reset = 1'b0;
    send_frame(11, -1, -1, -1, -1, 1'b0, 2'd0, 4'd0, 16'd0);
    send_frame(12, -1, -1, -1, -1, 1'b0, 2'd0, 4'd0, 16'd0);
    send_frame(13, -1, -1, -1, -1, 1'b1, 2'd2, 4'd0, 16'd1);
    send_frame(14, -1, -1, -1, -1, 1'b1, 2'd2, 4'd0, 16'd2);

    // One visible line too few: caught at the next frame boundary
    send_frame(15, -1, -1, 8, -1, 1'b1, 2'd2, 4'd0, 16'd3);
    push_fault(4'b0100, 12'(HT));
    send_frame(16, -1, -1, -1, -1, 1'b1, 2'd3, 4'b0100, 16'd4);

    repeat (4) @(negedge clock_50);
    chk("frame_queue_drained", fq.size(), 32'd0);
    chk("fault_queue_drained", flq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
